// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - opcodes, state encodings, trap causes and ImmSrc codes (MCCTRL_UPPER_IMM_EN adds lui/auipc)
package multicycle_ctrl_pkg;

  localparam logic [6:0] OP_LW    = 7'b0000011;
  localparam logic [6:0] OP_SW    = 7'b0100011;
  localparam logic [6:0] OP_RTYPE = 7'b0110011;
  localparam logic [6:0] OP_ITYPE = 7'b0010011;
  localparam logic [6:0] OP_BEQ   = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
`ifdef MCCTRL_UPPER_IMM_EN
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
`endif

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
`ifdef MCCTRL_UPPER_IMM_EN
  localparam logic [2:0] IMM_U = 3'b100;
`endif

  localparam logic [1:0] CAUSE_NONE    = 2'b00;
  localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
  localparam logic [1:0] CAUSE_BUS     = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
`ifdef MCCTRL_UPPER_IMM_EN
    S_UPPER    = 4'd12,
`endif
    S_TRAP     = 4'd11
  } state_e;

endpackage

// File: rtl/mc_immdec.sv
// rtl/mc_immdec.sv - combinational opcode to ImmSrc decode (MCCTRL_UPPER_IMM_EN adds U-type)
module mc_immdec
  import multicycle_ctrl_pkg::*;
(
  input  logic [6:0] op,
  output logic [2:0] imm_src
);

  // Immediate format follows the opcode; anything unrecognised uses the I format
  always_comb begin
    imm_src = IMM_I;
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      OP_JAL:  imm_src = IMM_J;
`ifdef MCCTRL_UPPER_IMM_EN
      OP_LUI,
      OP_AUIPC: imm_src = IMM_U;
`endif
      default: imm_src = IMM_I;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - multicycle RV32I control FSM with memory handshake watchdog (MCCTRL_UPPER_IMM_EN enables lui/auipc)
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       PCWrite,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [2:0] ImmSrc,
  output logic       instr_retire,
  output logic       trap,
  output logic [1:0] trap_cause
);

  // Count value seen during the last tolerated wait cycle
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             trap_q, trap_d;
  logic [1:0]       trap_cause_q, trap_cause_d;
  logic             mem_wait;
  logic             timeout_hit;

  mc_immdec u_immdec (
    .op      (op),
    .imm_src (ImmSrc)
  );

  assign mem_wait     = mem_req & ~mem_ready;
  // A ready response in the final tolerated cycle completes normally
  assign timeout_hit  = (TIMEOUT != 0) && mem_wait && (cnt_q == WD_LAST);
  assign trap         = trap_q;
  assign trap_cause   = trap_cause_q;

  // Moore output decode; only FETCH/MEMWRITE/BRANCH gate strobes on inputs
  always_comb begin
    mem_req      = 1'b0;
    AdrSrc       = 1'b0;
    IRWrite      = 1'b0;
    PCWrite      = 1'b0;
    MemWrite     = 1'b0;
    RegWrite     = 1'b0;
    ResultSrc    = 2'b00;
    ALUSrcA      = 2'b00;
    ALUSrcB      = 2'b00;
    ALUOp        = 2'b00;
    instr_retire = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'b10;
        ResultSrc = 2'b10;
        IRWrite   = mem_ready;
        PCWrite   = mem_ready;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc    = 2'b01;
        RegWrite     = 1'b1;
        instr_retire = 1'b1;
      end
      S_MEMWRITE: begin
        mem_req      = 1'b1;
        AdrSrc       = 1'b1;
        MemWrite     = 1'b1;
        instr_retire = mem_ready;
      end
      S_EXECR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      S_ALUWB: begin
        RegWrite     = 1'b1;
        instr_retire = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA      = 2'b10;
        ALUOp        = 2'b01;
        PCWrite      = zero;
        instr_retire = 1'b1;
      end
      S_JAL: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b10;
        PCWrite = 1'b1;
      end
`ifdef MCCTRL_UPPER_IMM_EN
      S_UPPER: begin
        ALUSrcA = (op == OP_LUI) ? 2'b11 : 2'b01;
        ALUSrcB = 2'b01;
      end
`endif
      default: begin
      end
    endcase
  end

  // Next state, sticky trap capture and watchdog count
  always_comb begin
    state_d      = state_q;
    trap_cause_d = trap_cause_q;
    trap_d       = trap_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_EXECR;
          OP_ITYPE:     state_d = S_EXECI;
          OP_BEQ:       state_d = S_BRANCH;
          OP_JAL:       state_d = S_JAL;
`ifdef MCCTRL_UPPER_IMM_EN
          OP_LUI,
          OP_AUIPC:     state_d = S_UPPER;
`endif
          default: begin
            state_d      = S_TRAP;
            trap_cause_d = CAUSE_ILLEGAL;
          end
        endcase
      end
      S_MEMADR:   state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  if (mem_ready) state_d = S_MEMWB;
      S_MEMWB:    state_d = S_FETCH;
      S_MEMWRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECR:    state_d = S_ALUWB;
      S_EXECI:    state_d = S_ALUWB;
      S_ALUWB:    state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JAL:      state_d = S_ALUWB;
`ifdef MCCTRL_UPPER_IMM_EN
      S_UPPER:    state_d = S_ALUWB;
`endif
      S_TRAP:     state_d = S_TRAP;
      default:    state_d = S_TRAP;
    endcase
    if (timeout_hit) begin
      state_d      = S_TRAP;
      trap_cause_d = CAUSE_BUS;
    end
    if (state_d == S_TRAP) trap_d = 1'b1;
    if (state_d != state_q) cnt_d = '0;
    else if (mem_wait)      cnt_d = cnt_q + CNT_W'(1);
    else                    cnt_d = cnt_q;
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_FETCH;
      cnt_q        <= '0;
      trap_q       <= 1'b0;
      trap_cause_q <= CAUSE_NONE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      trap_q       <= trap_d;
      trap_cause_q <= trap_cause_d;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - directed self-checking bench for multicycle_ctrl (expectations follow MCCTRL_UPPER_IMM_EN)
module tb_multicycle_ctrl;

  localparam int TO = 15;

  localparam int T_FETCH    = 0;
  localparam int T_DECODE   = 1;
  localparam int T_MEMADR   = 2;
  localparam int T_MEMREAD  = 3;
  localparam int T_MEMWB    = 4;
  localparam int T_MEMWRITE = 5;
  localparam int T_EXECR    = 6;
  localparam int T_EXECI    = 7;
  localparam int T_ALUWB    = 8;
  localparam int T_BRANCH   = 9;
  localparam int T_JAL      = 10;
  localparam int T_UPPER    = 11;
  localparam int T_TRAP     = 12;

  localparam logic [6:0] C_LW    = 7'b0000011;
  localparam logic [6:0] C_SW    = 7'b0100011;
  localparam logic [6:0] C_R     = 7'b0110011;
  localparam logic [6:0] C_I     = 7'b0010011;
  localparam logic [6:0] C_BEQ   = 7'b1100011;
  localparam logic [6:0] C_JAL   = 7'b1101111;
  localparam logic [6:0] C_LUI   = 7'b0110111;
  localparam logic [6:0] C_AUIPC = 7'b0010111;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] op;
  logic       zero;
  logic       mem_ready;
  logic       mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ALUOp;
  logic [2:0] ImmSrc;
  logic       instr_retire, trap;
  logic [1:0] trap_cause;
  logic [20:0] obs;

  int tests_run = 0;
  int failed    = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.TIMEOUT(TO), .CNT_W(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .op           (op),
    .zero         (zero),
    .mem_ready    (mem_ready),
    .mem_req      (mem_req),
    .AdrSrc       (AdrSrc),
    .IRWrite      (IRWrite),
    .PCWrite      (PCWrite),
    .MemWrite     (MemWrite),
    .RegWrite     (RegWrite),
    .ResultSrc    (ResultSrc),
    .ALUSrcA      (ALUSrcA),
    .ALUSrcB      (ALUSrcB),
    .ALUOp        (ALUOp),
    .ImmSrc       (ImmSrc),
    .instr_retire (instr_retire),
    .trap         (trap),
    .trap_cause   (trap_cause)
  );

  assign obs = {mem_req, AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, ResultSrc,
                ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_retire, trap, trap_cause};

  function automatic logic [2:0] exp_imm(input logic [6:0] o);
    case (o)
      C_SW:  return 3'b001;
      C_BEQ: return 3'b010;
      C_JAL: return 3'b011;
`ifdef MCCTRL_UPPER_IMM_EN
      C_LUI, C_AUIPC: return 3'b100;
`endif
      default: return 3'b000;
    endcase
  endfunction

  function automatic logic [20:0] exp_out(input int st, input logic mr, input logic z,
                                          input logic [6:0] o, input logic [1:0] cause);
    logic req, adr, irw, pcw, mw, rw, ret, trp;
    logic [1:0] rs, sa, sb, aop, cs;
    req = 0; adr = 0; irw = 0; pcw = 0; mw = 0; rw = 0; ret = 0; trp = 0;
    rs = 2'b00; sa = 2'b00; sb = 2'b00; aop = 2'b00; cs = 2'b00;
    case (st)
      T_FETCH:    begin req = 1; irw = mr; pcw = mr; sb = 2'b10; rs = 2'b10; end
      T_DECODE:   begin sa = 2'b01; sb = 2'b01; end
      T_MEMADR:   begin sa = 2'b10; sb = 2'b01; end
      T_MEMREAD:  begin req = 1; adr = 1; end
      T_MEMWB:    begin rs = 2'b01; rw = 1; ret = 1; end
      T_MEMWRITE: begin req = 1; adr = 1; mw = 1; ret = mr; end
      T_EXECR:    begin sa = 2'b10; aop = 2'b10; end
      T_EXECI:    begin sa = 2'b10; sb = 2'b01; aop = 2'b10; end
      T_ALUWB:    begin rw = 1; ret = 1; end
      T_BRANCH:   begin sa = 2'b10; aop = 2'b01; pcw = z; ret = 1; end
      T_JAL:      begin sa = 2'b01; sb = 2'b10; pcw = 1; end
      T_UPPER:    begin sa = (o == C_LUI) ? 2'b11 : 2'b01; sb = 2'b01; end
      T_TRAP:     begin trp = 1; cs = cause; end
      default:    begin end
    endcase
    return {req, adr, irw, pcw, mw, rw, rs, sa, sb, aop, exp_imm(o), ret, trp, cs};
  endfunction

  task automatic do_reset(input logic [6:0] o);
    op = o; rst = 1'b1; mem_ready = 1'b0; zero = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    logic [20:0] e;
    do_reset(C_LW);
    #1;
    e = exp_out(T_FETCH, 1'b0, 1'b0, op, 2'b00);
    tests_run++;
    if (obs !== e) begin failed++; $display("FAIL reset_idle: got %h expected %h", obs, e); end
    mem_ready = 1'b1; #1;
    e = exp_out(T_FETCH, 1'b1, 1'b0, op, 2'b00);
    tests_run++;
    if (obs !== e) begin failed++; $display("FAIL reset_ready: got %h expected %h", obs, e); end
    mem_ready = 1'b0;
  endtask

  task automatic test_lw();
    int stv[$];
    logic mrv[$];
    logic [20:0] e;
    int ret = 0;
    stv = '{T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMWB, T_FETCH};
    mrv = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    do_reset(C_LW);
    for (int i = 0; i < stv.size(); i++) begin
      mem_ready = mrv[i]; #1;
      e = exp_out(stv[i], mrv[i], zero, op, 2'b00);
      tests_run++;
      if (obs !== e) begin failed++; $display("FAIL lw step %0d: got %h expected %h", i, obs, e); end
      ret += int'(instr_retire);
      @(posedge clk); #1;
    end
    tests_run++;
    if (ret !== 1) begin failed++; $display("FAIL lw_retire_count: got %0d expected 1", ret); end
  endtask

  task automatic test_sw_wait();
    int stv[$];
    logic mrv[$];
    logic [20:0] e;
    stv = '{T_FETCH, T_DECODE, T_MEMADR, T_MEMWRITE, T_MEMWRITE, T_MEMWRITE, T_MEMWRITE, T_FETCH};
    mrv = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset(C_SW);
    for (int i = 0; i < stv.size(); i++) begin
      mem_ready = mrv[i]; #1;
      e = exp_out(stv[i], mrv[i], zero, op, 2'b00);
      tests_run++;
      if (obs !== e) begin failed++; $display("FAIL sw_wait step %0d: got %h expected %h", i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_beq();
    int stv[$];
    logic zv[$];
    logic [20:0] e;
    stv = '{T_FETCH, T_DECODE, T_BRANCH, T_FETCH, T_DECODE, T_BRANCH, T_FETCH};
    zv  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset(C_BEQ);
    for (int i = 0; i < stv.size(); i++) begin
      zero = zv[i];
      mem_ready = (i != stv.size() - 1);
      #1;
      e = exp_out(stv[i], mem_ready, zv[i], op, 2'b00);
      tests_run++;
      if (obs !== e) begin failed++; $display("FAIL beq step %0d: got %h expected %h", i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int stv[$];
    logic [6:0] opv[$];
    logic [20:0] e;
    stv = '{T_FETCH, T_DECODE, T_EXECR, T_ALUWB,
            T_FETCH, T_DECODE, T_EXECI, T_ALUWB,
            T_FETCH, T_DECODE, T_JAL,   T_ALUWB, T_FETCH};
    opv = '{C_R, C_R, C_R, C_R, C_I, C_I, C_I, C_I, C_JAL, C_JAL, C_JAL, C_JAL, C_LW};
    do_reset(C_R);
    for (int i = 0; i < stv.size(); i++) begin
      op = opv[i];
      mem_ready = (i != stv.size() - 1);
      #1;
      e = exp_out(stv[i], mem_ready, zero, op, 2'b00);
      tests_run++;
      if (obs !== e) begin failed++; $display("FAIL back_to_back step %0d: got %h expected %h", i, obs, e); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    logic [20:0] e;
    do_reset(7'b0000000);
    mem_ready = 1'b1; #1;
    e = exp_out(T_FETCH, 1'b1, 1'b0, op, 2'b00);
    tests_run++;
    if (obs !== e) begin failed++; $display("FAIL illegal_fetch: got %h expected %h", obs, e); end
    @(posedge clk); #1;
    e = exp_out(T_DECODE, 1'b1, 1'b0, op, 2'b00);
    tests_run++;
    if (obs !== e) begin failed++; $display("FAIL illegal_decode: got %h expected %h", obs, e); end
    @(posedge clk); #1;
    for (int i = 0; i < 20; i++) begin
      mem_ready = (i % 3 == 0);
      zero = (i % 2 == 0);
      #1;
      e = exp_out(T_TRAP, mem_ready, zero, op, 2'b01);
      tests_run++;
      if (obs !== e) begin failed++; $display("FAIL illegal_trap cycle %0d: got %h expected %h", i, obs, e); end
      @(posedge clk); #1;
    end
    rst = 1'b1; mem_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; #1;
    e = exp_out(T_FETCH, 1'b0, zero, op, 2'b00);
    tests_run++;
    if (obs !== e) begin failed++; $display("FAIL illegal_rst_exit: got %h expected %h", obs, e); end
  endtask

  task automatic test_timeout();
    logic [20:0] e;
    do_reset(C_LW);
    for (int i = 0; i < TO; i++) begin
      mem_ready = 1'b0; #1;
      e = exp_out(T_FETCH, 1'b0, 1'b0, op, 2'b00);
      tests_run++;
      if (obs !== e) begin failed++; $display("FAIL timeout_wait cycle %0d: got %h expected %h", i, obs, e); end
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      mem_ready = (i % 2 == 1); #1;
      e = exp_out(T_TRAP, mem_ready, 1'b0, op, 2'b10);
      tests_run++;
      if (obs !== e) begin failed++; $display("FAIL timeout_trap cycle %0d: got %h expected %h", i, obs, e); end
      @(posedge clk); #1;
    end
    do_reset(C_LW);
    for (int i = 0; i < TO - 1; i++) begin
      mem_ready = 1'b0; #1;
      e = exp_out(T_FETCH, 1'b0, 1'b0, op, 2'b00);
      tests_run++;
      if (obs !== e) begin failed++; $display("FAIL late_ready_wait cycle %0d: got %h expected %h", i, obs, e); end
      @(posedge clk); #1;
    end
    mem_ready = 1'b1; #1;
    e = exp_out(T_FETCH, 1'b1, 1'b0, op, 2'b00);
    tests_run++;
    if (obs !== e) begin failed++; $display("FAIL late_ready_fetch: got %h expected %h", obs, e); end
    @(posedge clk); #1;
    mem_ready = 1'b0; #1;
    e = exp_out(T_DECODE, 1'b0, 1'b0, op, 2'b00);
    tests_run++;
    if (obs !== e) begin failed++; $display("FAIL late_ready_decode: got %h expected %h", obs, e); end
  endtask

  task automatic test_rst_midwait();
    int stv[$];
    logic mrv[$];
    logic [20:0] e;
    stv = '{T_FETCH, T_DECODE, T_MEMADR, T_MEMREAD, T_MEMREAD};
    mrv = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    do_reset(C_LW);
    for (int i = 0; i < stv.size(); i++) begin
      mem_ready = mrv[i]; #1;
      e = exp_out(stv[i], mrv[i], zero, op, 2'b00);
      tests_run++;
      if (obs !== e) begin failed++; $display("FAIL rst_midwait step %0d: got %h expected %h", i, obs, e); end
      if (i == stv.size() - 1) rst = 1'b1;
      @(posedge clk); #1;
    end
    rst = 1'b0; #1;
    e = exp_out(T_FETCH, 1'b0, zero, op, 2'b00);
    tests_run++;
    if (obs !== e) begin failed++; $display("FAIL rst_midwait_exit: got %h expected %h", obs, e); end
  endtask

  task automatic test_upper();
    int stv[$];
    logic [1:0] cv;
    logic [20:0] e;
`ifdef MCCTRL_UPPER_IMM_EN
    stv = '{T_FETCH, T_DECODE, T_UPPER, T_ALUWB, T_FETCH};
    cv = 2'b00;
`else
    stv = '{T_FETCH, T_DECODE, T_TRAP, T_TRAP, T_TRAP};
    cv = 2'b01;
`endif
    for (int k = 0; k < 2; k++) begin
      do_reset((k == 0) ? C_LUI : C_AUIPC);
      for (int i = 0; i < stv.size(); i++) begin
        mem_ready = (i == 0); #1;
        e = exp_out(stv[i], mem_ready, zero, op, cv);
        tests_run++;
        if (obs !== e) begin failed++; $display("FAIL upper op %b step %0d: got %h expected %h", op, i, obs, e); end
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation bound expired");
    $fatal(1, "bench time limit");
  end

  initial begin
    rst = 1'b1; op = 7'b0; zero = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_lw();
    test_sw_wait();
    test_beq();
    test_back_to_back();
    test_illegal();
    test_timeout();
    test_rst_midwait();
    test_upper();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
